// File: rtl/inv_sbox_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : inv_sbox_engine
// Purpose  : Multi-cycle AES InvSubBytes over a 128-bit state, BYTES_PER_CYCLE
//            lanes per clock, valid/ready on both sides.
// Option   : SBOX_FWD_MODE_EN adds inv_mode (1 = InvS, 0 = forward S-box).
// Revision : 1.0
// ============================================================================
module inv_sbox_engine #(
    parameter int BYTES_PER_CYCLE = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
`ifdef SBOX_FWD_MODE_EN
    input  logic         inv_mode,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam int         c_num_groups = 16 / BYTES_PER_CYCLE;
    localparam logic [3:0] c_last_grp   = 4'(c_num_groups - 1);
    localparam logic [3:0] c_bpc        = 4'(BYTES_PER_CYCLE % 16);

    generate
        if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
              BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_bpc
            $error("inv_sbox_engine: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // ---------------- GF(2^8) arithmetic, modulus 9'h11B ----------------
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    // x^254 equals x^-1 for nonzero x and yields 0 for x = 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] r;
        sq = gf_mul(x, x);
        r  = sq;
        for (int i = 0; i < 6; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [7:0] t;
        for (int i = 0; i < 8; i++) begin
            t[i] = b[3'((i + 2) % 8)] ^ b[3'((i + 5) % 8)] ^ b[3'((i + 7) % 8)];
        end
        return gf_inv(t ^ 8'h05);
    endfunction

`ifdef SBOX_FWD_MODE_EN
    function automatic logic [7:0] fwd_sbox(input logic [7:0] b);
        logic [7:0] v;
        logic [7:0] t;
        v = gf_inv(b);
        for (int i = 0; i < 8; i++) begin
            t[i] = v[i] ^ v[3'((i + 4) % 8)] ^ v[3'((i + 5) % 8)] ^
                   v[3'((i + 6) % 8)] ^ v[3'((i + 7) % 8)];
        end
        return t ^ 8'h63;
    endfunction
`endif

    // ---------------- State ----------------
    state_t       state_q, state_d;
    logic [3:0]   grp_q, grp_d;
    logic [127:0] work_q, work_d;
    logic         in_ready_q, in_ready_d;
    logic         out_valid_q, out_valid_d;
    logic         busy_q, busy_d;
`ifdef SBOX_FWD_MODE_EN
    logic         mode_q, mode_d;
`endif

    logic [BYTES_PER_CYCLE*8-1:0] lane_out;
    logic [127:0]                 subst;

    // Lane l always serves byte grp*BPC + l of the work register.
    generate
        for (genvar l = 0; l < BYTES_PER_CYCLE; l++) begin : g_lane
            logic [3:0] byte_idx;
            logic [7:0] lane_in;
            assign byte_idx = grp_q * c_bpc + 4'(l);
            assign lane_in  = work_q[{byte_idx, 3'b000} +: 8];
`ifdef SBOX_FWD_MODE_EN
            assign lane_out[l*8 +: 8] = mode_q ? inv_sbox(lane_in) : fwd_sbox(lane_in);
`else
            assign lane_out[l*8 +: 8] = inv_sbox(lane_in);
`endif
        end

        for (genvar b = 0; b < 16; b++) begin : g_byte
            assign subst[b*8 +: 8] = (grp_q == 4'(b / BYTES_PER_CYCLE)) ?
                                     lane_out[(b % BYTES_PER_CYCLE)*8 +: 8] :
                                     work_q[b*8 +: 8];
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        grp_d       = grp_q;
        work_d      = work_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
`ifdef SBOX_FWD_MODE_EN
        mode_d      = mode_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    work_d     = in_data;
                    grp_d      = 4'd0;
                    state_d    = S_BUSY;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
`ifdef SBOX_FWD_MODE_EN
                    mode_d     = inv_mode;
`endif
                end
            end
            S_BUSY: begin
                work_d = subst;
                if (grp_q == c_last_grp) begin
                    grp_d       = 4'd0;
                    state_d     = S_DONE;
                    out_valid_d = 1'b1;
                end else begin
                    grp_d = grp_q + 4'd1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    busy_d      = 1'b0;
                end
            end
            default: begin
                state_d     = S_IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            grp_q       <= 4'd0;
            work_q      <= 128'h0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef SBOX_FWD_MODE_EN
            mode_q      <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            grp_q       <= grp_d;
            work_q      <= work_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
`ifdef SBOX_FWD_MODE_EN
            mode_q      <= mode_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = work_q;
    assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_inv_sbox_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_inv_sbox_engine
// Purpose  : Table-driven check of inv_sbox_engine at BPC = 4, 1 and 16.
// Revision : 1.0
// ============================================================================
module tb_inv_sbox_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         in_valid  [3];
    logic         in_ready  [3];
    logic         out_valid [3];
    logic         out_ready [3];
    logic         busy      [3];
    logic         inv_mode  [3];
    logic [127:0] in_data   [3];
    logic [127:0] out_data  [3];

    int n_checks = 0;
    int n_pass   = 0;

    generate
        for (genvar g = 0; g < 3; g++) begin : g_dut
            localparam int BPC = (g == 0) ? 4 : ((g == 1) ? 1 : 16);
            inv_sbox_engine #(.BYTES_PER_CYCLE(BPC)) u_dut (
                .clk       (clk),
                .rst_n     (rst_n),
                .in_valid  (in_valid[g]),
                .in_ready  (in_ready[g]),
                .in_data   (in_data[g]),
`ifdef SBOX_FWD_MODE_EN
                .inv_mode  (inv_mode[g]),
`endif
                .out_valid (out_valid[g]),
                .out_ready (out_ready[g]),
                .out_data  (out_data[g]),
                .busy      (busy[g])
            );
        end
    endgenerate

    logic [7:0] fwd_tab [256];
    logic [7:0] inv_tab [256];

    typedef struct {
        int           dut;
        logic         mode;
        logic [127:0] din;
        logic [127:0] exp;
        string        name;
    } vec_t;
    vec_t vecs[$];

    localparam logic [127:0] ALL52 = {16{8'h52}};
    localparam logic [127:0] ALL48 = {16{8'h48}};
    localparam logic [127:0] KNOWN_IN  = 128'h63636363_63636363_636363FF_16007C63;
    localparam logic [127:0] KNOWN_EXP = 128'h00000000_00000000_0000007D_FF520100;

    function automatic int lat_exp(input int d);
        return (d == 0) ? 4 : ((d == 1) ? 16 : 1);
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic run_state(input int d, input logic [127:0] din, input logic mode,
                             output logic [127:0] res, output int lat);
        @(negedge clk);
        in_valid[d] = 1'b1;
        in_data[d]  = din;
        inv_mode[d] = mode;
        @(posedge clk);
        #1;
        in_valid[d] = 1'b0;
        in_data[d]  = ~din;
        inv_mode[d] = ~mode;
        lat = 0;
        while (!out_valid[d] && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        res = out_data[d];
    endtask

    task automatic release_out(input int d, input string name);
        out_ready[d] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[d] = 1'b0;
        check({name, " out_valid after ready"}, 128'(out_valid[d]), 128'd0);
        check({name, " in_ready after ready"}, 128'(in_ready[d]), 128'd1);
    endtask

    task automatic add_vec(input int d, input logic m, input logic [127:0] di,
                           input logic [127:0] ex, input string nm);
        vec_t v;
        v.dut = d; v.mode = m; v.din = di; v.exp = ex; v.name = nm;
        vecs.push_back(v);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] res;
        logic [127:0] din;
        logic [127:0] ex;
        logic [7:0]   bv;
        int           lat;

        fwd_tab = '{
            8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
            8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
            8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
            8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
            8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
            8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
            8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
            8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
            8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
            8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
            8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
            8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
            8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
            8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
            8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
            8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
        };
        for (int i = 0; i < 256; i++) inv_tab[fwd_tab[i]] = 8'(i);

        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) begin
            in_valid[d] = 1'b0; out_ready[d] = 1'b0; inv_mode[d] = 1'b1; in_data[d] = '0;
        end

        // Reset state on every instance.
        #12;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("reset in_ready d%0d", d),  128'(in_ready[d]),  128'd1);
            check($sformatf("reset out_valid d%0d", d), 128'(out_valid[d]), 128'd0);
            check($sformatf("reset busy d%0d", d),      128'(busy[d]),      128'd0);
            check($sformatf("reset out_data d%0d", d),  out_data[d],        128'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        add_vec(0, 1'b1, ALL52, ALL48, "all52");
        add_vec(0, 1'b1, KNOWN_IN, KNOWN_EXP, "known");
        for (int d = 0; d < 3; d++) begin
            for (int s = 0; s < 16; s++) begin
                for (int b = 0; b < 16; b++) begin
                    bv = 8'(s * 16 + b);
                    din[b*8 +: 8] = bv;
                    ex[b*8 +: 8]  = inv_tab[bv];
                end
                add_vec(d, 1'b1, din, ex, $sformatf("inv sweep d%0d s%0d", d, s));
            end
        end
`ifdef SBOX_FWD_MODE_EN
        add_vec(0, 1'b0, 128'h0, {16{8'h63}}, "fwd zero");
        add_vec(0, 1'b0, {16{8'h53}}, {16{8'hED}}, "fwd 53");
        for (int d = 1; d < 3; d++) begin
            for (int s = 0; s < 16; s++) begin
                for (int b = 0; b < 16; b++) begin
                    bv = 8'(s * 16 + b);
                    din[b*8 +: 8] = bv;
                    ex[b*8 +: 8]  = fwd_tab[bv];
                end
                add_vec(d, 1'b0, din, ex, $sformatf("fwd sweep d%0d s%0d", d, s));
            end
        end
`endif

        foreach (vecs[k]) begin
            run_state(vecs[k].dut, vecs[k].din, vecs[k].mode, res, lat);
            check({vecs[k].name, " latency"}, 128'(lat), 128'(lat_exp(vecs[k].dut)));
            check({vecs[k].name, " data"}, res, vecs[k].exp);
            release_out(vecs[k].dut, vecs[k].name);
        end

        // Backpressure: DONE holds while a competing input is offered.
        run_state(0, ALL52, 1'b1, res, lat);
        check("bp latency", 128'(lat), 128'd4);
        in_valid[0] = 1'b1;
        in_data[0]  = KNOWN_IN;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("bp out_valid c%0d", c), 128'(out_valid[0]), 128'd1);
            check($sformatf("bp out_data c%0d", c),  out_data[0],        ALL48);
            check($sformatf("bp in_ready c%0d", c),  128'(in_ready[0]),  128'd0);
            check($sformatf("bp busy c%0d", c),      128'(busy[0]),      128'd1);
        end
        in_valid[0] = 1'b0;
        release_out(0, "bp");
        check("bp busy after ready", 128'(busy[0]), 128'd0);
        check("bp out_data kept in idle", out_data[0], ALL48);

        // Reset after two processing cycles.
        @(negedge clk);
        in_valid[0] = 1'b1;
        in_data[0]  = KNOWN_IN;
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst out_valid", 128'(out_valid[0]), 128'd0);
        check("midrst in_ready",  128'(in_ready[0]),  128'd1);
        check("midrst out_data",  out_data[0],        128'h0);
        check("midrst busy",      128'(busy[0]),      128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_state(0, KNOWN_IN, 1'b1, res, lat);
        check("post-rst latency", 128'(lat), 128'd4);
        check("post-rst data", res, KNOWN_EXP);
        release_out(0, "post-rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
